// File: rtl/spmv_isect_feeder.sv
// ---------------------------------------------------------------------------
// spmv_isect_feeder
//
// Purpose:
//   Upstream feeder for the signed streaming MAC. It merges two index-sorted
//   sparse vectors, a CSR row of A and a CSC column of B, by index. Each
//   matching index produces one operand pair per cycle for the MAC. The feeder
//   also drives the MAC's ce/sload so that every dot product starts a fresh
//   accumulation. The final pair carries mac_last so the downstream drain knows
//   when to capture the result.
//
// Ports:
//   clk, rst_n               clock (rising edge) / async active-low reset
//   a_valid/a_ready          stream A handshake (ready is combinational)
//   a_idx/a_val/a_last       stream A element: unsigned index, signed value, end
//   b_*                      same fields for stream B
//   mac_ce                   operand pair valid (MAC clock enable)
//   mac_a, mac_b             operand pair (zero when mac_ce=0)
//   mac_sload                first pair of a dot product
//   mac_last                 final pair of a dot product
//   busy                     elements consumed, result not yet flushed
//   order_err                sticky: an index failed to strictly increase
// ---------------------------------------------------------------------------
module spmv_isect_feeder #(
  parameter int SIZEIN = 16,
  parameter int IDXW   = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a_valid,
  output logic                     a_ready,
  input  logic [IDXW-1:0]          a_idx,
  input  logic signed [SIZEIN-1:0] a_val,
  input  logic                     a_last,
  input  logic                     b_valid,
  output logic                     b_ready,
  input  logic [IDXW-1:0]          b_idx,
  input  logic signed [SIZEIN-1:0] b_val,
  input  logic                     b_last,
  output logic                     mac_ce,
  output logic signed [SIZEIN-1:0] mac_a,
  output logic signed [SIZEIN-1:0] mac_b,
  output logic                     mac_sload,
  output logic                     mac_last,
  output logic                     busy,
  output logic                     order_err
);

  localparam logic [1:0] ST_MERGE   = 2'd0;
  localparam logic [1:0] ST_DRAIN_A = 2'd1;
  localparam logic [1:0] ST_DRAIN_B = 2'd2;
  localparam logic [1:0] ST_FLUSH   = 2'd3;

  logic [1:0]               r_state;
  logic signed [SIZEIN-1:0] r_pa;
  logic signed [SIZEIN-1:0] r_pb;
  logic                     r_pfirst;
  logic                     r_pvalid;
  logic                     r_started;
  logic                     r_busy;
  logic                     r_order_err;
  logic                     r_mac_ce;
  logic signed [SIZEIN-1:0] r_mac_a;
  logic signed [SIZEIN-1:0] r_mac_b;
  logic                     r_mac_sload;
  logic                     r_mac_last;

  logic                     w_a_lt;
  logic                     w_a_eq;
  logic                     w_a_pop;
  logic                     w_b_pop;
  logic                     w_match;
  logic                     w_a_end;
  logic                     w_b_end;
  logic [1:0]               w_pop;
  logic [1:0]               w_last;
  logic [1:0]               w_ord_bad;
  logic [IDXW-1:0]          w_idx [2];

  assign w_a_lt = (a_idx < b_idx);
  assign w_a_eq = (a_idx == b_idx);

  // In MERGE the stream holding the smaller index advances. Both streams
  // advance on equal indices. Nothing advances until both sides are valid.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    case (r_state)
      ST_MERGE: begin
        if (a_valid && b_valid) begin
          a_ready = w_a_lt | w_a_eq;
          b_ready = ~w_a_lt;
        end
      end
      ST_DRAIN_A: a_ready = 1'b1;
      ST_DRAIN_B: b_ready = 1'b1;
      default: ;
    endcase
  end

  assign w_a_pop = a_valid & a_ready;
  assign w_b_pop = b_valid & b_ready;
  assign w_match = (r_state == ST_MERGE) & w_a_pop & w_b_pop;
  assign w_a_end = w_a_pop & a_last;
  assign w_b_end = w_b_pop & b_last;

  // Per-stream ordering monitor. The previous index is forgotten after the
  // last element, so the first index of the next vector is never compared
  // against the tail of the previous one.
  assign w_pop    = {w_b_pop, w_a_pop};
  assign w_last   = {b_last, a_last};
  assign w_idx[0] = a_idx;
  assign w_idx[1] = b_idx;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_order
      logic [IDXW-1:0] r_prev_idx;
      logic            r_prev_vld;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_prev_idx <= '0;
          r_prev_vld <= 1'b0;
        end else if (w_pop[gi]) begin
          r_prev_idx <= w_idx[gi];
          r_prev_vld <= ~w_last[gi];
        end
      end

      assign w_ord_bad[gi] = w_pop[gi] & r_prev_vld & (w_idx[gi] <= r_prev_idx);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_MERGE;
      r_pa        <= '0;
      r_pb        <= '0;
      r_pfirst    <= 1'b0;
      r_pvalid    <= 1'b0;
      r_started   <= 1'b0;
      r_busy      <= 1'b0;
      r_order_err <= 1'b0;
      r_mac_ce    <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_sload <= 1'b0;
      r_mac_last  <= 1'b0;
    end else begin
      // MAC outputs are single-cycle pulses and read as zero when idle.
      r_mac_ce    <= 1'b0;
      r_mac_a     <= '0;
      r_mac_b     <= '0;
      r_mac_sload <= 1'b0;
      r_mac_last  <= 1'b0;

      if (|w_ord_bad) begin
        r_order_err <= 1'b1;
      end
      if (w_a_pop || w_b_pop) begin
        r_busy <= 1'b1;
      end

      case (r_state)
        ST_MERGE: begin
          // A match is always held back one step. This lets the terminal
          // pair be tagged with mac_last once the end of a vector is known.
          if (w_match) begin
            if (r_pvalid) begin
              r_mac_ce    <= 1'b1;
              r_mac_a     <= r_pa;
              r_mac_b     <= r_pb;
              r_mac_sload <= r_pfirst;
              r_pfirst    <= 1'b0;
            end else begin
              r_pfirst  <= ~r_started;
              r_started <= 1'b1;
            end
            r_pa     <= a_val;
            r_pb     <= b_val;
            r_pvalid <= 1'b1;
          end

          if (w_a_end && w_b_end) begin
            r_state <= ST_FLUSH;
          end else if (w_a_end) begin
            r_state <= ST_DRAIN_B;
          end else if (w_b_end) begin
            r_state <= ST_DRAIN_A;
          end
        end

        ST_DRAIN_A: begin
          if (w_a_end) begin
            r_state <= ST_FLUSH;
          end
        end

        ST_DRAIN_B: begin
          if (w_b_end) begin
            r_state <= ST_FLUSH;
          end
        end

        default: begin  // ST_FLUSH
          // With an empty intersection a 0*0 pair is emitted with sload and
          // last together, so the MAC still produces exactly one result (0).
          r_mac_ce   <= 1'b1;
          r_mac_last <= 1'b1;
          if (r_pvalid) begin
            r_mac_a     <= r_pa;
            r_mac_b     <= r_pb;
            r_mac_sload <= r_pfirst;
          end else begin
            r_mac_sload <= 1'b1;
          end
          r_pvalid  <= 1'b0;
          r_pfirst  <= 1'b0;
          r_started <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_MERGE;
        end
      endcase
    end
  end

  assign mac_ce    = r_mac_ce;
  assign mac_a     = r_mac_a;
  assign mac_b     = r_mac_b;
  assign mac_sload = r_mac_sload;
  assign mac_last  = r_mac_last;
  assign busy      = r_busy;
  assign order_err = r_order_err;

endmodule

// File: tb/tb_spmv_isect_feeder.sv
// ---------------------------------------------------------------------------
// tb_spmv_isect_feeder
//
// Self-checking bench for spmv_isect_feeder. Streams are described as queues
// of (idx, val, last) elements. The expected MAC pairs come from a set-based
// intersection model: for each vector, the pairs are the B elements whose
// index also appears in A. The first pair carries sload and the final pair
// carries last. An empty intersection yields a single 0*0 pair with both
// flags set.
// ---------------------------------------------------------------------------
module tb_spmv_isect_feeder;
  localparam int SIZEIN = 16;
  localparam int IDXW   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     a_valid = 1'b0;
  logic                     a_ready;
  logic [IDXW-1:0]          a_idx = '0;
  logic signed [SIZEIN-1:0] a_val = '0;
  logic                     a_last = 1'b0;
  logic                     b_valid = 1'b0;
  logic                     b_ready;
  logic [IDXW-1:0]          b_idx = '0;
  logic signed [SIZEIN-1:0] b_val = '0;
  logic                     b_last = 1'b0;
  logic                     mac_ce;
  logic signed [SIZEIN-1:0] mac_a;
  logic signed [SIZEIN-1:0] mac_b;
  logic                     mac_sload;
  logic                     mac_last;
  logic                     busy;
  logic                     order_err;

  typedef struct {int idx; int val; bit last;} elem_t;
  typedef struct {int a; int b; bit s; bit l;} pair_t;

  elem_t stream_a[$];
  elem_t stream_b[$];
  pair_t exp_q[$];
  pair_t cap_q[$];

  int total = 0;
  int bad = 0;
  int drv_timeout = 0;
  int gap_a = 0;
  int gap_b = 0;

  spmv_isect_feeder #(.SIZEIN(SIZEIN), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_idx(a_idx), .a_val(a_val), .a_last(a_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_idx(b_idx), .b_val(b_val), .b_last(b_last),
    .mac_ce(mac_ce), .mac_a(mac_a), .mac_b(mac_b), .mac_sload(mac_sload),
    .mac_last(mac_last), .busy(busy), .order_err(order_err)
  );

  always #5 clk = ~clk;

  // Capture every emitted pair; idle cycles must present all-zero operands.
  always @(negedge clk) begin
    pair_t p;
    if (rst_n) begin
      if (mac_ce) begin
        p.a = int'(mac_a);
        p.b = int'(mac_b);
        p.s = mac_sload;
        p.l = mac_last;
        cap_q.push_back(p);
      end else begin
        total++;
        if (mac_a !== 0 || mac_b !== 0 || mac_sload !== 1'b0 || mac_last !== 1'b0) begin
          bad++;
          $display("FAIL idle_zero: got a=%0d b=%0d sload=%b last=%b, required all 0",
                   mac_a, mac_b, mac_sload, mac_last);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_a(input int idx, input int val, input bit last);
    elem_t e;
    e.idx = idx; e.val = val; e.last = last;
    stream_a.push_back(e);
  endtask

  task automatic push_b(input int idx, input int val, input bit last);
    elem_t e;
    e.idx = idx; e.val = val; e.last = last;
    stream_b.push_back(e);
  endtask

  task automatic clear_streams();
    stream_a.delete();
    stream_b.delete();
  endtask

  // Random strictly increasing vector over indices 0..15.
  task automatic gen_vec(input bit to_a);
    int picks[$];
    int v;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 2) == 0) picks.push_back(k);
    end
    if (picks.size() == 0) picks.push_back(int'($urandom_range(0, 15)));
    for (int i = 0; i < picks.size(); i++) begin
      v = int'($urandom_range(0, 65535)) - 32768;
      if (to_a) push_a(picks[i], v, i == picks.size() - 1);
      else      push_b(picks[i], v, i == picks.size() - 1);
    end
  endtask

  task automatic model_expected();
    int ia;
    int ib;
    int aval[int];
    pair_t vec_q[$];
    pair_t p;
    ia = 0;
    ib = 0;
    exp_q.delete();
    while (ia < stream_a.size() && ib < stream_b.size()) begin
      aval.delete();
      vec_q.delete();
      do begin
        aval[stream_a[ia].idx] = stream_a[ia].val;
        ia++;
      end while (ia < stream_a.size() && !stream_a[ia-1].last);
      do begin
        if (aval.exists(stream_b[ib].idx)) begin
          p.a = aval[stream_b[ib].idx];
          p.b = stream_b[ib].val;
          p.s = 1'b0;
          p.l = 1'b0;
          vec_q.push_back(p);
        end
        ib++;
      end while (ib < stream_b.size() && !stream_b[ib-1].last);
      if (vec_q.size() == 0) begin
        p.a = 0; p.b = 0; p.s = 1'b1; p.l = 1'b1;
        exp_q.push_back(p);
      end else begin
        p = vec_q[0];
        p.s = 1'b1;
        vec_q[0] = p;
        p = vec_q[vec_q.size()-1];
        p.l = 1'b1;
        vec_q[vec_q.size()-1] = p;
        for (int i = 0; i < vec_q.size(); i++) exp_q.push_back(vec_q[i]);
      end
    end
  endtask

  task automatic drive_a_stream();
    int gap;
    int t;
    bit done;
    for (int i = 0; i < stream_a.size(); i++) begin
      gap = (gap_a > 0) ? int'($urandom_range(0, gap_a)) : 0;
      for (int g = 0; g < gap; g++) begin
        a_valid = 1'b0;
        @(posedge clk); #1;
      end
      a_valid = 1'b1;
      a_idx   = IDXW'(stream_a[i].idx);
      a_val   = SIZEIN'(stream_a[i].val);
      a_last  = stream_a[i].last;
      t = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (a_ready) done = 1'b1;
        else begin
          t++;
          if (t > 200) begin drv_timeout++; done = 1'b1; end
        end
        @(posedge clk); #1;
      end
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic drive_b_stream();
    int gap;
    int t;
    bit done;
    for (int i = 0; i < stream_b.size(); i++) begin
      gap = (gap_b > 0) ? int'($urandom_range(0, gap_b)) : 0;
      for (int g = 0; g < gap; g++) begin
        b_valid = 1'b0;
        @(posedge clk); #1;
      end
      b_valid = 1'b1;
      b_idx   = IDXW'(stream_b[i].idx);
      b_val   = SIZEIN'(stream_b[i].val);
      b_last  = stream_b[i].last;
      t = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (b_ready) done = 1'b1;
        else begin
          t++;
          if (t > 200) begin drv_timeout++; done = 1'b1; end
        end
        @(posedge clk); #1;
      end
    end
    b_valid = 1'b0;
    b_last  = 1'b0;
  endtask

  // Drive both streams, then compare the captured pairs with the model.
  task automatic run_streams(input string name);
    int t;
    int n;
    model_expected();
    cap_q.delete();
    drv_timeout = 0;
    @(posedge clk); #1;
    fork
      drive_a_stream();
      drive_b_stream();
    join
    total++;
    if (drv_timeout != 0) begin
      bad++;
      $display("FAIL %s handshake: got %0d stalled elements, required 0", name, drv_timeout);
    end
    t = 0;
    while (cap_q.size() < exp_q.size() && t < 100) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL %s pair_count: got %0d, required %0d", name, cap_q.size(), exp_q.size());
    end
    n = (cap_q.size() < exp_q.size()) ? cap_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      total++;
      $display("%s pair %0d: a=%0d b=%0d sload=%0b last=%0b", name, i,
               cap_q[i].a, cap_q[i].b, cap_q[i].s, cap_q[i].l);
      if (cap_q[i].a !== exp_q[i].a || cap_q[i].b !== exp_q[i].b ||
          cap_q[i].s !== exp_q[i].s || cap_q[i].l !== exp_q[i].l) begin
        bad++;
        $display("FAIL %s pair %0d: got (%0d,%0d,s%0b,l%0b), required (%0d,%0d,s%0b,l%0b)",
                 name, i, cap_q[i].a, cap_q[i].b, cap_q[i].s, cap_q[i].l,
                 exp_q[i].a, exp_q[i].b, exp_q[i].s, exp_q[i].l);
      end
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s busy_after: got %b, required 0", name, busy);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (mac_ce !== 1'b0 || mac_a !== 0 || mac_b !== 0 || mac_sload !== 1'b0 || mac_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_mac: got ce=%b a=%0d b=%0d sload=%b last=%b, required all 0",
               mac_ce, mac_a, mac_b, mac_sload, mac_last);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b, required 0", busy); end
    total++;
    if (order_err !== 1'b0) begin bad++; $display("FAIL reset_order_err: got %b, required 0", order_err); end
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: got a=%b b=%b, required 0 0", a_ready, b_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_basic();
    int dot;
    clear_streams();
    gap_a = 0; gap_b = 0;
    push_a(1, 3, 0); push_a(4, 5, 0); push_a(7, 2, 1);
    push_b(4, 10, 0); push_b(7, 6, 0); push_b(9, 1, 1);
    run_streams("basic");
    dot = 0;
    foreach (cap_q[i]) dot += cap_q[i].a * cap_q[i].b;
    total++;
    if (dot !== 62) begin bad++; $display("FAIL basic_dot: got %0d, required 62", dot); end
  endtask

  task automatic test_empty();
    clear_streams();
    gap_a = 0; gap_b = 0;
    push_a(2, 7, 1);
    push_b(3, 9, 1);
    run_streams("empty");
  endtask

  task automatic test_single_drain();
    cap_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_idx = 16'd5; a_val = -16'sd4; a_last = 1'b1;
    b_valid = 1'b1; b_idx = 16'd5; b_val = 16'sd8; b_last = 1'b0;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      bad++; $display("FAIL drain_match_ready: got a=%b b=%b, required 1 1", a_ready, b_ready);
    end
    @(posedge clk); #1;
    // A stays valid with a small index: it must not be consumed while B drains.
    a_idx = 16'd0; a_val = 16'sd77; a_last = 1'b0;
    b_idx = 16'd6; b_val = 16'sd1; b_last = 1'b0;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      bad++; $display("FAIL drain_ready_1: got a=%b b=%b, required 0 1", a_ready, b_ready);
    end
    @(posedge clk); #1;
    b_idx = 16'd9; b_val = 16'sd2; b_last = 1'b1;
    @(negedge clk);
    total++;
    if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
      bad++; $display("FAIL drain_ready_2: got a=%b b=%b, required 0 1", a_ready, b_ready);
    end
    total++;
    if (cap_q.size() != 0) begin
      bad++; $display("FAIL drain_early: got %0d pairs before b_last, required 0", cap_q.size());
    end
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0; b_last = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 1) begin
      bad++; $display("FAIL drain_count: got %0d pairs, required 1", cap_q.size());
    end else begin
      $display("drain pair 0: a=%0d b=%0d sload=%0b last=%0b",
               cap_q[0].a, cap_q[0].b, cap_q[0].s, cap_q[0].l);
      total++;
      if (cap_q[0].a !== -4 || cap_q[0].b !== 8 || cap_q[0].s !== 1'b1 || cap_q[0].l !== 1'b1) begin
        bad++;
        $display("FAIL drain_pair: got (%0d,%0d,s%0b,l%0b), required (-4,8,s1,l1)",
                 cap_q[0].a, cap_q[0].b, cap_q[0].s, cap_q[0].l);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_streams();
    gen_vec(1'b1); gen_vec(1'b1);
    gen_vec(1'b0); gen_vec(1'b0);
    gap_a = 3; gap_b = 0;
    run_streams("b2b");
  endtask

  task automatic test_random();
    int nv;
    for (int it = 0; it < 6; it++) begin
      clear_streams();
      nv = int'($urandom_range(1, 3));
      for (int v = 0; v < nv; v++) begin
        gen_vec(1'b1);
        gen_vec(1'b0);
      end
      gap_a = int'($urandom_range(0, 2));
      gap_b = int'($urandom_range(0, 2));
      run_streams($sformatf("rand%0d", it));
    end
  endtask

  task automatic test_order_err();
    cap_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_idx = 16'd4; a_val = 16'sd1; a_last = 1'b0;
    b_valid = 1'b1; b_idx = 16'd5; b_val = 16'sd3; b_last = 1'b1;
    @(posedge clk); #1;
    total++;
    if (order_err !== 1'b0) begin bad++; $display("FAIL order_first: got %b, required 0", order_err); end
    a_idx = 16'd4; a_val = 16'sd2; a_last = 1'b1;
    @(posedge clk); #1;
    total++;
    if (order_err !== 1'b1) begin bad++; $display("FAIL order_rise: got %b, required 1", order_err); end
    a_valid = 1'b0; a_last = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    b_valid = 1'b0; b_last = 1'b0;
    total++;
    if (cap_q.size() != 1 || cap_q[0].a !== 0 || cap_q[0].b !== 0 || cap_q[0].s !== 1'b1 || cap_q[0].l !== 1'b1) begin
      bad++;
      $display("FAIL order_flush: got %0d pairs, required one (0,0,s1,l1)", cap_q.size());
    end
    total++;
    if (order_err !== 1'b1) begin bad++; $display("FAIL order_hold: got %b, required 1", order_err); end
    rst_n = 1'b0;
    #1;
    total++;
    if (order_err !== 1'b0) begin bad++; $display("FAIL order_clear: got %b, required 0", order_err); end
    @(negedge clk);
    rst_n = 1'b1;
    $display("order_err test complete");
  endtask

  task automatic test_reset_mid();
    cap_q.delete();
    @(posedge clk); #1;
    a_valid = 1'b1; a_idx = 16'd3; a_val = 16'sd1; a_last = 1'b0;
    b_valid = 1'b1; b_idx = 16'd3; b_val = 16'sd5; b_last = 1'b0;
    @(posedge clk); #1;
    a_valid = 1'b0; b_valid = 1'b0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy: got %b, required 1", busy); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (mac_ce !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL mid_reset: got ce=%b busy=%b, required 0 0", mac_ce, busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cap_q.size() != 0) begin
      bad++; $display("FAIL mid_discard: got %0d pairs, required 0", cap_q.size());
    end
    clear_streams();
    gap_a = 0; gap_b = 0;
    push_a(2, 7, 0); push_a(5, 1, 1);
    push_b(5, 3, 1);
    run_streams("after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_single_drain();
    test_back_to_back();
    test_random();
    test_order_err();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
